// File: rtl/glb_read_arbiter.sv
// rtl/glb_read_arbiter.sv - round-robin arbiter sharing one GLB read port among N_PE PEs
//
// Purpose:
//   Grants at most one PE read request per cycle onto the GLB read port,
//   tracks each granted read through a LAT-deep one-hot tag pipeline and
//   steers the returning data to its owner.  A flush request halts new
//   grants, waits for all in-flight reads to return and then reports done.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pe_req       per-PE request, held with its address until granted
//   pe_addr      per-PE address, PE i at [i*ADDR_W +: ADDR_W]
//   pe_gnt       one-hot grant (combinational, same cycle as glb_ren)
//   glb_ready    GLB can accept a read this cycle
//   glb_ren      GLB read enable
//   glb_raddr    address of the granted PE (0 when idle)
//   glb_rdata    GLB read data, valid LAT cycles after glb_ren
//   pe_rvalid    one-hot owner of glb_rdata this cycle
//   pe_rdata     glb_rdata passthrough
//   flush        drain request
//   flush_done   high while drained and flush held
//   busy         any request pending or any read in flight
module glb_read_arbiter #(
  parameter int N_PE   = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PE-1:0]        pe_req,
  input  logic [N_PE*ADDR_W-1:0] pe_addr,
  output logic [N_PE-1:0]        pe_gnt,
  input  logic                   glb_ready,
  output logic                   glb_ren,
  output logic [ADDR_W-1:0]      glb_raddr,
  input  logic [DATA_W-1:0]      glb_rdata,
  output logic [N_PE-1:0]        pe_rvalid,
  output logic [DATA_W-1:0]      pe_rdata,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   busy
);

  localparam int PTR_W = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [N_PE-1:0]    tag_q [LAT];
  logic [CNT_W-1:0]   inflight;

  logic               grant_ok;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     idx;

  // Reset also masks the grant so nothing is issued during the reset cycle.
  assign grant_ok = !rst && (state_q == S_RUN) && !flush && glb_ready;

  // Round-robin search starting at ptr; idx has one spare bit so ptr+k
  // can be folded back into range with a single subtract.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    idx    = '0;
    pe_gnt = '0;
    if (grant_ok) begin
      for (int k = 0; k < N_PE; k++) begin
        idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
        if (idx >= (PTR_W+1)'(N_PE)) begin
          idx = idx - (PTR_W+1)'(N_PE);
        end
        if (!found && pe_req[idx[PTR_W-1:0]]) begin
          found = 1'b1;
          win   = idx[PTR_W-1:0];
        end
      end
    end
    if (found) begin
      pe_gnt[win] = 1'b1;
    end
  end

  assign glb_ren   = found;
  assign glb_raddr = found ? pe_addr[int'(win)*ADDR_W +: ADDR_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (win == PTR_W'(N_PE - 1)) ? '0 : win + 1'b1;
    end
  end

  // Tag pipeline: a zero word enters whenever no grant is made, so stalls
  // and drains keep shifting and responses stay aligned to the GLB latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= pe_gnt;
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) begin
      if (|tag_q[k]) begin
        inflight = inflight + CNT_W'(1);
      end
    end
  end

  // Reads still in the pipe when reset hits are discarded, including the
  // one that would have returned during the reset cycle itself.
  assign pe_rvalid = rst ? '0 : tag_q[LAT-1];
  assign pe_rdata  = glb_rdata;
  assign busy      = (|pe_req) || (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Drain completes even if flush drops meanwhile; DONE is always
        // visited for at least one cycle.
        if (inflight == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        flush_done = !rst;
        if (!flush) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_glb_read_arbiter.sv
// tb/tb_glb_read_arbiter.sv - self-checking bench for glb_read_arbiter
module tb_glb_read_arbiter;

  localparam int N_PE   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LAT    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_PE-1:0]        pe_req;
  logic [N_PE*ADDR_W-1:0] pe_addr;
  logic [N_PE-1:0]        pe_gnt;
  logic                   glb_ready;
  logic                   glb_ren;
  logic [ADDR_W-1:0]      glb_raddr;
  logic [DATA_W-1:0]      glb_rdata;
  logic [N_PE-1:0]        pe_rvalid;
  logic [DATA_W-1:0]      pe_rdata;
  logic                   flush;
  logic                   flush_done;
  logic                   busy;

  glb_read_arbiter #(
    .N_PE(N_PE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .pe_req(pe_req), .pe_addr(pe_addr), .pe_gnt(pe_gnt),
    .glb_ready(glb_ready), .glb_ren(glb_ren), .glb_raddr(glb_raddr),
    .glb_rdata(glb_rdata), .pe_rvalid(pe_rvalid), .pe_rdata(pe_rdata),
    .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding reads as (return cycle, owner) records,
  // next-preferred PE index, and flush phase 0=running 1=draining 2=drained.
  typedef struct {
    int              due;
    logic [N_PE-1:0] owner;
  } rd_t;
  rd_t rq[$];
  int  cyc      = 0;
  int  m_ptr    = 0;
  int  m_phase  = 0;
  bit  auto_drop = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N_PE-1:0]   e_gnt;
    logic [ADDR_W-1:0] e_addr;
    logic [N_PE-1:0]   e_rv;
    int                pend;
    e_gnt  = '0;
    e_addr = '0;
    e_rv   = '0;
    @(negedge clk);
    if (!rst && m_phase == 0 && !flush && glb_ready) begin
      for (int k = 0; k < N_PE; k++) begin
        int i;
        i = (m_ptr + k) % N_PE;
        if (e_gnt == '0 && pe_req[i]) begin
          e_gnt[i] = 1'b1;
          e_addr   = pe_addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
    pend = rq.size();
    if (!rst && pend > 0 && rq[0].due == cyc) e_rv = rq[0].owner;
    chk("pe_gnt", 32'(pe_gnt), 32'(e_gnt));
    chk("glb_ren", 32'(glb_ren), 32'(e_gnt != '0));
    chk("glb_raddr", 32'(glb_raddr), 32'(e_addr));
    chk("pe_rvalid", 32'(pe_rvalid), 32'(e_rv));
    chk("pe_rdata", 32'(pe_rdata), 32'(glb_rdata));
    chk("flush_done", 32'(flush_done), 32'(!rst && m_phase == 2));
    chk("busy", 32'(busy), 32'((pe_req != '0) || pend != 0));
    @(posedge clk);
    #1;
    if (rst) begin
      rq.delete();
      m_ptr   = 0;
      m_phase = 0;
    end else begin
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      if (e_gnt != '0) begin
        rq.push_back('{due: cyc + LAT, owner: e_gnt});
        for (int i = 0; i < N_PE; i++) if (e_gnt[i]) m_ptr = (i + 1) % N_PE;
      end
      case (m_phase)
        0: if (flush) m_phase = 1;
        1: if (pend == 0) m_phase = 2;
        default: if (!flush) m_phase = 0;
      endcase
    end
    cyc++;
    if (auto_drop) pe_req = pe_req & ~e_gnt;
    glb_rdata = DATA_W'($urandom);
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    pe_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    pe_req    = '0;
    pe_addr   = '0;
    glb_ready = 1'b1;
    glb_rdata = '0;
    flush     = 1'b0;

    // Reset state
    do_reset(2);
    step();

    // PE2 alone, addr 0x15; then PE0+PE3 together proves ptr moved to 3
    set_addr(2, 8'h15);
    pe_req = 4'b0100;
    step();
    step();
    step();
    set_addr(0, 8'hA0);
    set_addr(3, 8'h3C);
    pe_req = 4'b1001;
    repeat (5) step();

    // All PEs hold requests continuously from reset
    do_reset(1);
    auto_drop = 1'b0;
    set_addr(1, 8'h11);
    pe_req = 4'b1111;
    repeat (6) step();
    pe_req = '0;
    repeat (3) step();

    // PEs 1 and 3 stalled by glb_ready for 3 cycles
    auto_drop = 1'b1;
    do_reset(1);
    pe_req    = 4'b1010;
    glb_ready = 1'b0;
    repeat (3) step();
    glb_ready = 1'b1;
    repeat (4) step();

    // Two grants then flush; drain, done, resume
    pe_req = 4'b0011;
    step();
    step();
    flush  = 1'b1;
    pe_req = 4'b0100;
    begin
      int n;
      n = 0;
      while (!flush_done && n < 10) begin
        step();
        n++;
      end
      chk("flush_done_within_bound", 32'(flush_done), 32'd1);
    end
    step();
    flush = 1'b0;
    repeat (4) step();

    // Flush released while still draining
    pe_req = 4'b0001;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (5) step();

    // Grant to PE0 then reset on the next cycle discards the read
    pe_req = 4'b0001;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();

    // PE3 and PE0 requesting repeatedly: alternation and ptr wrap
    auto_drop = 1'b0;
    pe_req    = 4'b1001;
    repeat (6) step();
    pe_req    = '0;
    repeat (3) step();

    // Randomized traffic
    auto_drop = 1'b1;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N_PE; i++) begin
        if (!pe_req[i]) begin
          set_addr(i, ADDR_W'($urandom));
          if ($urandom_range(2, 0) == 0) pe_req[i] = 1'b1;
        end
      end
      glb_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) flush = ~flush;
      rst = ($urandom_range(79, 0) == 0);
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
